elevator_display_scan: RTL and testbench
========================================

Name: elevator_display_scan

Overview:
- Reader/consumer side of the elevator controller's display interface: takes current-floor code, next-floor code and emergency flag, and drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Sits between the elevator FSM outputs and the board display pins.
- Contains a refresh divider, a digit scanner, a frame-synchronous input snapshot, a direction indicator and an emergency blink timer.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot; legal range >= 2.
- BLINK_TICKS, 250, digit slots per blink half-period in emergency; legal range >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- disp_cur  input  4  current floor code from the elevator FSM
- disp_next  input  4  next floor code from the elevator FSM
- emerg  input  1  emergency flag from the elevator FSM
- an  output  4  digit anodes, active low, an[0] = rightmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low; held 1 (off)

Behaviour:
- Reset is asynchronous and active-high, with one clock.
- Reset values:
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - Refresh counter = 0, digit index = 0, blink counter = 0, blink phase = 1 (on).
  - Snapshot cur/next = 0, snapshot emerg = 0.
- Refresh counter: counts 0..REFRESH_DIV-1, then wraps to 0. tick = (count == REFRESH_DIV-1).
- Digit index (2 bits): increments on tick and wraps 3 -> 0. One frame = 4 slots.
- Snapshot:
  - On tick with index == 3, capture disp_cur, disp_next and emerg.
  - Inputs are never used directly, so mid-frame input changes cannot tear the display.
  - New values appear starting with slot 0 of the next frame.
- Digit contents, from snapshot values:
  - digit0 = next floor glyph.
  - digit1 = current floor glyph.
  - digit2 = direction: up (next > cur) = 7'b1111110 (seg a); down (next < cur) = 7'b1110111 (seg d); idle (equal) or emergency = dash 7'b0111111.
  - digit3 = 'E' 7'b0000110 in emergency, otherwise blank 7'b1111111.
- Glyphs:
  - 0 = 7'b1000000, 1 = 7'b1111001, 2 = 7'b0100100, 3 = 7'b0110000, 4 = 7'b0011001, 5 = 7'b0010010, 6 = 7'b0000010, 7 = 7'b1111000, 8 = 7'b0000000, 9 = 7'b0010000.
  - Codes 10..15 render as dash 7'b0111111.
- Direction compare is unsigned 4-bit, applied to the raw codes, including invalid codes.
- Outputs are registered with 1-cycle latency: an/seg on cycle n+1 reflect the index and snapshot at cycle n.
  - an = one-hot low of the index, e.g. index 2 -> 4'b1011.
- Blink:
  - While snapshot emerg = 1, the blink counter counts ticks 0..BLINK_TICKS-1; at the terminal count it wraps and toggles the blink phase.
  - Phase 0 forces an = 4'b1111; seg keeps its computed value.
  - While snapshot emerg = 0, the blink counter is held at 0 and the phase at 1.
  - Emergency entry always starts in the visible phase.
- Emergency exit happens when snapshot emerg falls. The display returns to normal at the next frame boundary, with no latching here; the FSM owns stickiness.
- Simultaneous events:
  - When a tick at index 3 coincides with a snapshot update, the index wraps to 0 and slot 0 uses the new snapshot.
  - When a blink toggle coincides with emerg deasserting in the snapshot, the clear wins: phase = 1.
- Reset asserted mid-frame: all state returns to reset values immediately, without waiting for clk. The first cycle after deassertion registers digit 0 from snapshot 0, so on the next edge an = 4'b1110 and seg = glyph '0'.

Decomposition:
- Package elevator_disp_pkg holds:
  - the segment glyph constants (digits 0-9, DASH, BLANK, E, UP, DOWN);
  - the 2-bit digit index type;
  - the anode one-hot constants.
- One combinational sub-module, seg7_decode: 4-bit code -> 7-bit active-low pattern, using dash for 10..15. It is instantiated for both floor digits.
- The scan, snapshot and blink logic stay in the top module.

Test Plan:
- Reset: hold reset while toggling clk with inputs nonzero -> an = 4'b1111, seg = 7'b1111111, dp = 1. First edge after release -> an = 4'b1110, seg = 7'b1000000.
- Scan (REFRESH_DIV = 4): cur = 1, next = 1 -> an cycles 1110, 1101, 1011, 0111 every 4 clks; seg shows '1', '1', dash, blank.
- Snapshot timing: change next 0 -> 2 while index = 1 -> digit0 shows '0' for the rest of the frame and '2' (7'b0100100) from the next slot 0. With cur = 0, digit2 = 7'b1111110 (up).
- Down/invalid: cur = 2, next = 0 -> digit2 = 7'b1110111. Then next = 4'hB -> digit0 = 7'b0111111, digit2 = up.
- Emergency blink (REFRESH_DIV = 4, BLINK_TICKS = 2): emerg = 1 -> after the frame boundary, digit3 = 7'b0000110 and digit2 = dash. an alternates visible / all-off every 2 slots. Drop emerg -> blinking stops after the next frame boundary, with phase on.
- Reset mid-operation: assert reset during emergency at index 2 -> outputs go off asynchronously. After release, normal scan from digit0 with a cleared snapshot (floor '0', no 'E').

Source files
------------

// File: rtl/elevator_disp_pkg.sv
// elevator_disp_pkg: segment glyphs, digit index type and anode patterns for the floor display
package elevator_disp_pkg;
   typedef logic [1:0] digit_idx_t;
   localparam digit_idx_t IDX_LAST = 2'd3;
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_UP = 7'b1111110;
   localparam logic [6:0] SEG_DOWN = 7'b1110111;
   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam logic [3:0][3:0] AN_ONEHOT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: floor code to active-low 7-segment pattern, codes 10..15 shown as a dash
module seg7_decode
   import elevator_disp_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] pattern
);
   // glyph lookup
   always_comb begin
      case (code)
         4'd0: pattern = SEG_0;
         4'd1: pattern = SEG_1;
         4'd2: pattern = SEG_2;
         4'd3: pattern = SEG_3;
         4'd4: pattern = SEG_4;
         4'd5: pattern = SEG_5;
         4'd6: pattern = SEG_6;
         4'd7: pattern = SEG_7;
         4'd8: pattern = SEG_8;
         4'd9: pattern = SEG_9;
         default: pattern = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/elevator_display_scan.sv
// elevator_display_scan: multiplexed 4-digit display of next/current floor, direction and emergency blink
module elevator_display_scan
   import elevator_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_TICKS = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] disp_cur,
   input  logic [3:0] disp_next,
   input  logic       emerg,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   digit_idx_t    idx_q, idx_d;
   logic [3:0]    cur_q, cur_d, next_q, next_d;
   logic          emg_q, emg_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          phase_q, phase_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic [6:0]    cur_glyph, next_glyph, dir_glyph;
   logic          tick, frame_end, blink_run, blink_wrap;

   seg7_decode u_cur  (.code(cur_q),  .pattern(cur_glyph));
   seg7_decode u_next (.code(next_q), .pattern(next_glyph));

   // divider, scanner, frame snapshot, blink timer and the digit mux feeding the output registers
   always_comb begin
      tick = cnt_q == CNT_LAST;
      frame_end = tick && idx_q == IDX_LAST;
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      idx_d = tick ? idx_q + 2'd1 : idx_q;
      cur_d = frame_end ? disp_cur : cur_q;
      next_d = frame_end ? disp_next : next_q;
      emg_d = frame_end ? emerg : emg_q;
      blink_run = emg_q && emg_d;
      blink_wrap = tick && bcnt_q == BLINK_LAST;
      bcnt_d = !blink_run ? '0 : !tick ? bcnt_q : blink_wrap ? '0 : bcnt_q + 1'b1;
      phase_d = !blink_run ? 1'b1 : blink_wrap ? ~phase_q : phase_q;
      dir_glyph = (emg_q || next_q == cur_q) ? SEG_DASH : next_q > cur_q ? SEG_UP : SEG_DOWN;
      seg_d = idx_q == 2'd0 ? next_glyph :
              idx_q == 2'd1 ? cur_glyph :
              idx_q == 2'd2 ? dir_glyph :
              emg_q ? SEG_E : SEG_BLANK;
      an_d = phase_q ? AN_ONEHOT[idx_q] : AN_OFF;
   end

   // state and registered outputs; reset blanks the display and clears the snapshot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         idx_q <= '0;
         cur_q <= '0;
         next_q <= '0;
         emg_q <= 1'b0;
         bcnt_q <= '0;
         phase_q <= 1'b1;
         an_q <= AN_OFF;
         seg_q <= SEG_BLANK;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         cur_q <= cur_d;
         next_q <= next_d;
         emg_q <= emg_d;
         bcnt_q <= bcnt_d;
         phase_q <= phase_d;
         an_q <= an_d;
         seg_q <= seg_d;
      end
   end

   assign an = an_q;
   assign seg = seg_q;
   assign dp = 1'b1;
endmodule

// File: tb/tb_elevator_display_scan.sv
// tb_elevator_display_scan: table, hand sequences and random stimulus against a frame/slot reference model
module tb_elevator_display_scan;
   localparam int R = 4;
   localparam int B = 2;
   localparam int F = 4 * R;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] disp_cur = 4'd7, disp_next = 4'd9;
   logic emerg = 1'b1;
   logic [3:0] an;
   logic [6:0] seg;
   logic dp;

   int total = 0, bad = 0;
   int n = 0, start_slot = 0, last_d = 0;
   logic [3:0] m_cur = '0, m_next = '0;
   logic m_emg = 1'b0;
   logic [6:0] gl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct {
      logic [3:0] c;
      logic [3:0] x;
      logic [3:0][6:0] d;
   } vec_t;
   vec_t tbl [8];

   elevator_display_scan #(.REFRESH_DIV(R), .BLINK_TICKS(B)) dut (
      .clk(clk), .reset(reset), .disp_cur(disp_cur), .disp_next(disp_next),
      .emerg(emerg), .an(an), .seg(seg), .dp(dp));

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] c);
      return c < 4'd10 ? gl[c] : 7'h3f;
   endfunction

   function automatic logic [6:0] exp_seg(input int d);
      case (d)
         0: return glyph(m_next);
         1: return glyph(m_cur);
         2: return (m_emg || m_next == m_cur) ? 7'h3f : (m_next > m_cur ? 7'h7e : 7'h77);
         default: return m_emg ? 7'h06 : 7'h7f;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      n = 0;
      m_cur = '0;
      m_next = '0;
      m_emg = 1'b0;
      start_slot = 0;
   endtask

   // called at a negedge; drives inputs for cycle n, checks the outputs registered from it
   task automatic step(input logic [3:0] c, input logic [3:0] x, input logic e);
      int slot;
      logic [3:0] ea;
      logic [6:0] es;
      disp_cur = c;
      disp_next = x;
      emerg = e;
      slot = n / R;
      last_d = slot % 4;
      es = exp_seg(last_d);
      ea = (!m_emg || ((slot - start_slot) / B) % 2 == 0) ? ~(4'b0001 << last_d) : 4'hf;
      @(posedge clk);
      #1;
      chk("an", an, ea);
      chk("seg", seg, es);
      chk("dp", dp, 1);
      if (n % F == F - 1) begin
         if (e && !m_emg) start_slot = slot + 1;
         m_cur = c;
         m_next = x;
         m_emg = e;
      end
      n++;
      @(negedge clk);
   endtask

   task automatic run_to_frame(input logic [3:0] c, input logic [3:0] x, input logic e);
      step(c, x, e);
      while (n % F != 0) step(c, x, e);
   endtask

   initial begin
      int off;
      logic [3:0] rc, rx;
      logic re;
      tbl[0] = '{4'd1, 4'd1, {7'h7f, 7'h3f, 7'h79, 7'h79}};
      tbl[1] = '{4'd0, 4'd2, {7'h7f, 7'h7e, 7'h40, 7'h24}};
      tbl[2] = '{4'd2, 4'd0, {7'h7f, 7'h77, 7'h24, 7'h40}};
      tbl[3] = '{4'd2, 4'hb, {7'h7f, 7'h7e, 7'h24, 7'h3f}};
      tbl[4] = '{4'd9, 4'd7, {7'h7f, 7'h77, 7'h10, 7'h78}};
      tbl[5] = '{4'hf, 4'hf, {7'h7f, 7'h3f, 7'h3f, 7'h3f}};
      tbl[6] = '{4'hc, 4'd3, {7'h7f, 7'h77, 7'h3f, 7'h30}};
      tbl[7] = '{4'd5, 4'd8, {7'h7f, 7'h7e, 7'h12, 7'h00}};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", an, 4'hf);
      chk("rst_seg", seg, 7'h7f);
      chk("rst_dp", dp, 1);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(4'd1, 4'd1, 1'b0);
      chk("first_an", an, 4'he);
      chk("first_seg", seg, 7'h40);
      run_to_frame(4'd1, 4'd1, 1'b0);
      for (int v = 0; v < 8; v++)
         for (int i = 0; i < 3 * F; i++) begin
            step(tbl[v].c, tbl[v].x, 1'b0);
            if (i >= 2 * F) chk("table_seg", seg, tbl[v].d[last_d]);
         end
      run_to_frame(4'd0, 4'd0, 1'b0);
      run_to_frame(4'd0, 4'd0, 1'b0);
      repeat (R) step(4'd0, 4'd0, 1'b0);
      repeat (3 * R) step(4'd0, 4'd2, 1'b0);
      step(4'd0, 4'd2, 1'b0);
      chk("snap_an", an, 4'he);
      chk("snap_d0", seg, 7'h24);
      repeat (2 * R) step(4'd0, 4'd2, 1'b0);
      chk("snap_d2", seg, 7'h7e);
      run_to_frame(4'd3, 4'd3, 1'b1);
      off = 0;
      for (int i = 0; i < 2 * F; i++) begin
         step(4'd3, 4'd3, 1'b1);
         if (an == 4'hf) off++;
         if (i == 0) chk("emerg_entry_vis", an, 4'he);
         if (i == 2 * R) chk("emerg_d2", seg, 7'h3f);
         if (i == 3 * R) chk("emerg_d3", seg, 7'h06);
      end
      chk("blink_off_cycles", off, 4 * R);
      run_to_frame(4'd3, 4'd3, 1'b0);
      off = 0;
      repeat (F) begin
         step(4'd3, 4'd3, 1'b0);
         if (an == 4'hf) off++;
      end
      chk("exit_off_cycles", off, 0);
      run_to_frame(4'd3, 4'd3, 1'b1);
      repeat (2 * R) step(4'd3, 4'd3, 1'b1);
      reset = 1'b1;
      #1;
      chk("async_an", an, 4'hf);
      chk("async_seg", seg, 7'h7f);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      step(4'd3, 4'd5, 1'b0);
      chk("rerst_an", an, 4'he);
      chk("rerst_seg", seg, 7'h40);
      run_to_frame(4'd3, 4'd5, 1'b0);
      repeat (F) step(4'd3, 4'd5, 1'b0);
      rc = 4'd3;
      rx = 4'd5;
      re = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) rc = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) rx = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 59) == 0) re = ~re;
         step(rc, rx, re);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
